// File: rtl/lc3_dmem_responder.sv
// lc3_dmem_responder: data-memory responder for the LC-3 MemAccess stage.
// Accepts one read/write request at a time, waits WAIT_STATES cycles, then
// completes with a one-cycle complete_data pulse. The RAM is flop-based so it
// can be restored to INIT_VAL by the asynchronous reset.
// Optional build macro: DMEM_RANGE_CHK_EN adds the range_err output and
// rejects addresses >= DEPTH instead of wrapping them modulo DEPTH.
module lc3_dmem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] INIT_VAL    = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DMem_req,
  input  logic        DMem_rd,
  input  logic [15:0] DMem_addr,
  input  logic [15:0] DMem_din,
  output logic [15:0] memout,
  output logic        complete_data,
  output logic        busy
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic        range_err
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam bit          HAS_WAIT = (WAIT_STATES > 0);
  localparam int          WSM1     = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
  localparam logic [3:0]  WS_INIT  = WSM1[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_rd;
  logic [AW-1:0]   r_idx;
  logic [15:0]     r_din;
  logic            r_oor;
  logic [15:0]     r_memout;
  logic            r_complete;
  logic            r_busy;
  logic            r_range_err;
  logic [15:0]     r_mem [DEPTH];

  logic            w_in_oor;
  logic            w_accept;
  logic            w_enter_done;
  logic [AW-1:0]   w_acc_idx;
  logic            w_acc_rd;
  logic            w_acc_oor;

`ifdef DMEM_RANGE_CHK_EN
  assign w_in_oor  = (DMem_addr >= 16'(DEPTH));
  assign range_err = r_range_err;
`else
  // Upper address bits are deliberately discarded: addresses wrap modulo DEPTH.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^DMem_addr[15:AW];
  assign w_in_oor         = 1'b0;
`endif

  assign w_accept     = (r_state == S_IDLE) && DMem_req;
  // DONE is entered straight from IDLE when there are no wait states,
  // otherwise from WAIT once the counter has run out.
  assign w_enter_done = (w_accept && !HAS_WAIT) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // Select the request attributes that apply on the edge entering DONE: live
  // inputs when coming directly from IDLE, latched copies otherwise.
  always_comb begin
    w_acc_idx = r_idx;
    w_acc_rd  = r_rd;
    w_acc_oor = r_oor;
    if (r_state == S_IDLE) begin
      w_acc_idx = DMem_addr[AW-1:0];
      w_acc_rd  = DMem_rd;
      w_acc_oor = w_in_oor;
    end
  end

  // Request FSM, registered outputs and RAM storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rd        <= 1'b0;
      r_idx       <= '0;
      r_din       <= 16'h0000;
      r_oor       <= 1'b0;
      r_memout    <= 16'h0000;
      r_complete  <= 1'b0;
      r_busy      <= 1'b0;
      r_range_err <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= INIT_VAL;
      end
    end else begin
      r_complete  <= 1'b0;
      r_range_err <= 1'b0;
      // Read data is captured as DONE is entered so it is valid alongside
      // complete_data; earlier writes have already committed by then.
      if (w_enter_done) begin
        r_complete  <= 1'b1;
        r_range_err <= w_acc_oor;
        if (w_acc_rd) begin
          r_memout <= w_acc_oor ? 16'h0000 : r_mem[w_acc_idx];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (DMem_req) begin
            r_rd   <= DMem_rd;
            r_idx  <= DMem_addr[AW-1:0];
            r_din  <= DMem_din;
            r_oor  <= w_in_oor;
            r_busy <= 1'b1;
            if (HAS_WAIT) begin
              r_state <= S_WAIT;
              r_cnt   <= WS_INIT;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!r_rd && !r_oor) begin
            r_mem[r_idx] <= r_din;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign memout        = r_memout;
  assign complete_data = r_complete;
  assign busy          = r_busy;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Testbench for lc3_dmem_responder: four instances with WAIT_STATES 1, 0, 3
// and 15. Requests push their expected response into a per-instance queue; a
// monitor pops and compares whenever complete_data is seen.
module tb_lc3_dmem_responder;

  localparam int N = 4;
  localparam int WS_TAB [N] = '{1, 0, 3, 15};
`ifdef DMEM_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req, rd, cmpl, busy, rerr;
  logic [15:0]  addr [N];
  logic [15:0]  din  [N];
  logic [15:0]  mout [N];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] data;
    logic        re;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q [N][$];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lc3_dmem_responder #(
      .DEPTH(256), .WAIT_STATES(WS_TAB[g]), .INIT_VAL(16'h0000)
    ) u_dut (
      .clock(clk), .reset(rst_n), .DMem_req(req[g]), .DMem_rd(rd[g]),
      .DMem_addr(addr[g]), .DMem_din(din[g]), .memout(mout[g]),
      .complete_data(cmpl[g]), .busy(busy[g])
`ifdef DMEM_RANGE_CHK_EN
      , .range_err(rerr[g])
`endif
    );
  end
`ifndef DMEM_RANGE_CHK_EN
  assign rerr = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse must match the oldest outstanding entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (cmpl[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_complete inst=%0d memout=%h expected no pulse", i, mout[i]);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("memout_i%0d", i), {16'h0, mout[i]}, {16'h0, e.data});
            chk($sformatf("latency_i%0d", i), cyc - e.acc, e.lat);
            if (RC) chk($sformatf("range_err_i%0d", i), {31'h0, rerr[i]}, {31'h0, e.re});
          end
        end
      end
    end
  end

  // Issue one request on instance i, hold it until completion, then check
  // that busy spanned exactly WS+1 cycles and cleared afterwards.
  task automatic xact(input int i, input bit r, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] em,
                      input bit re, input bit chg);
    exp_t e;
    int   nb;
    bit   done;
    @(negedge clk);
    req[i] = 1'b1; rd[i] = r; addr[i] = a; din[i] = d;
    e.data = em; e.re = re; e.acc = cyc; e.lat = WS_TAB[i] + 1;
    q[i].push_back(e);
    @(negedge clk);
    if (chg) begin
      din[i]  = 16'hFFFF;
      addr[i] = a + 16'd1;
    end
    done = 1'b0;
    nb   = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (busy[i]) nb++;
      if (cmpl[i]) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout_i%0d addr=%h no complete_data within 40 cycles", i, a);
    end else begin
      chk($sformatf("busy_cycles_i%0d", i), nb, WS_TAB[i] + 1);
    end
    req[i] = 1'b0;
    @(negedge clk);
    chk($sformatf("busy_clear_i%0d", i), {31'h0, busy[i]}, 32'h0);
    chk($sformatf("single_pulse_i%0d", i), {31'h0, cmpl[i]}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; rd[i] = 1'b0; addr[i] = 16'h0; din[i] = 16'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_memout_i%0d", i), {16'h0, mout[i]}, 32'h0);
      chk($sformatf("rst_complete_i%0d", i), {31'h0, cmpl[i]}, 32'h0);
      chk($sformatf("rst_busy_i%0d", i), {31'h0, busy[i]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Read after reset, then write/read and input-change immunity.
    xact(0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    xact(0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
    xact(0, 1'b0, 16'h0020, 16'h1234, 16'hBEEF, 1'b0, 1'b1);
    xact(0, 1'b1, 16'h0020, 16'h0000, 16'h1234, 1'b0, 1'b0);
    xact(0, 1'b1, 16'h0021, 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Out-of-range address: wraps without the macro, rejected with it.
    xact(0, 1'b0, 16'h0105, 16'h5555, 16'h0000, RC, 1'b0);
    xact(0, 1'b1, 16'h0005, 16'h0000, RC ? 16'h0000 : 16'h5555, 1'b0, 1'b0);
    xact(0, 1'b1, 16'h0105, 16'h0000, RC ? 16'h0000 : 16'h5555, RC, 1'b0);

    // Latency sweep for 0, 3 and 15 wait states.
    xact(1, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(2, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(3, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(1, 1'b0, 16'h0002, 16'h7E01, 16'h0000, 1'b0, 1'b0);
    xact(1, 1'b1, 16'h0002, 16'h0000, 16'h7E01, 1'b0, 1'b0);
    xact(3, 1'b0, 16'h0001, 16'hC3C3, 16'h0000, 1'b0, 1'b0);
    xact(3, 1'b1, 16'h0001, 16'h0000, 16'hC3C3, 1'b0, 1'b0);

    // Reset during the WAIT phase of a write.
    @(negedge clk);
    req[0] = 1'b1; rd[0] = 1'b0; addr[0] = 16'h0030; din[0] = 16'hAAAA;
    @(negedge clk);
    chk("midop_busy_before", {31'h0, busy[0]}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midop_busy_after", {31'h0, busy[0]}, 32'h0);
    chk("midop_complete", {31'h0, cmpl[0]}, 32'h0);
    chk("midop_memout", {16'h0, mout[0]}, 32'h0);
    chk("midop_memout_i3", {16'h0, mout[3]}, 32'h0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b1, 16'h0030, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(0, 1'b1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0);
    xact(3, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("queue_empty_i%0d", i), q[i].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_dmem_responder.md
Name: lc3_dmem_responder

Overview:
- Data-memory responder at the far end of the memaccess_out bus.
- Accepts read/write requests from the MemAccess stage and returns read data on memout after a programmable number of wait states.
- Drives complete_data back to the pipeline so MemAccess can stall.
- Holds a synchronous word-addressed data RAM of DEPTH x 16 bits.

Parameters:
- DEPTH, 256, number of 16-bit words; power of 2, minimum 4.
- WAIT_STATES, 1, extra cycles between request acceptance and completion; 0..15.
- INIT_VAL, 16'h0000, value loaded into every word at reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- DMem_req  input  1  request strobe, held until complete_data
- DMem_rd  input  1  1 = read, 0 = write
- DMem_addr  input  16  word address
- DMem_din  input  16  write data
- memout  output  16  read data, valid when complete_data=1 for a read
- complete_data  output  1  one-cycle completion pulse
- busy  output  1  high while a request is in progress

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; memout=16'h0000; complete_data=0; busy=0; wait counter=0.
  - All RAM words = INIT_VAL; RAM clears on reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If DMem_req=1, latch DMem_rd, DMem_addr[log2(DEPTH)-1:0] and DMem_din; busy=1.
  - Go to WAIT if WAIT_STATES>0 with counter=WAIT_STATES-1, else go to DONE.
- WAIT: counter decrements each cycle; at counter==0 go to DONE.
- DONE (one cycle):
  - complete_data=1.
  - Read: memout=RAM[latched addr].
  - Write: RAM[latched addr]=latched din; memout holds its previous value.
  - Next state IDLE, busy=0 on the following edge.
- Latency: accept edge to complete_data high = WAIT_STATES+1 cycles (WAIT_STATES=0 gives complete_data in the cycle after acceptance).
- Back-to-back requests:
  - DMem_req sampled again in IDLE the cycle after DONE, so minimum request spacing is WAIT_STATES+2 cycles.
  - The requester deasserts or re-presents DMem_req after complete_data.
- Request changes: changes to DMem_rd, DMem_addr or DMem_din after acceptance are ignored; latched values are used.
- DMem_req dropped mid-transaction: the transaction still completes; no abort.
- memout holds its last read value whenever complete_data=0.
- Address wrap: upper address bits above log2(DEPTH) are ignored (modulo DEPTH), unless DMEM_RANGE_CHK_EN is defined.
- Read after write to the same address: the later read returns the newly written data. No internal forwarding is needed because the write commits in DONE before the next accept.
- Reset asserted mid-transaction: immediate return to IDLE, outputs go to reset values, RAM reinitialised, no complete_data pulse.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined:
  - Adds output range_err (1 bit, reset 0).
  - In DONE, if the latched DMem_addr >= DEPTH: range_err=1 for that cycle alongside complete_data.
  - Read returns memout=16'h0000; write is dropped with RAM unchanged.
- Not defined:
  - No range_err port.
  - Address is taken modulo DEPTH; all accesses are performed.

Test Plan:
- Reset check: reset=0 then 1; read addr 0x0005 with DEPTH=256, WAIT_STATES=1 -> memout=0x0000, complete_data 2 cycles after accept, busy high 2 cycles.
- Write/read: write 0xBEEF to 0x0010, then read 0x0010 -> second transaction memout=0xBEEF; memout unchanged (0x0000) during the write completion.
- Latency sweep: WAIT_STATES=0,3,15; read 0x0001 -> complete_data at 1, 4 and 16 cycles after accept; exactly one pulse each.
- Input-change immunity: accept write 0x1234 to 0x0020, change DMem_din to 0xFFFF and DMem_addr to 0x0021 during WAIT -> reads return 0x0020=0x1234 and 0x0021=0x0000.
- Reset mid-op: assert reset during WAIT of a write 0xAAAA to 0x0030 -> no complete_data, busy=0 immediately; subsequent read of 0x0030 returns 0x0000.
- Range check, DEPTH=256: write 0x5555 to 0x0105.
  - With DMEM_RANGE_CHK_EN: range_err=1 with complete_data; read 0x0005 returns 0x0000.
  - Without the macro: read 0x0005 returns 0x5555.
